// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared types and constants for the UART command-frame receiver.
//   state_t      : frame assembly state (opcode, data high, data low)
//   FRAME_BYTES  : bytes per command frame
//   *_MSB/*_LSB  : positions of the three byte fields inside the 24-bit command
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    WAIT_OP = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  localparam int FRAME_BYTES = 3;

  localparam int OP_MSB = 23;
  localparam int OP_LSB = 16;
  localparam int HI_MSB = 15;
  localparam int HI_LSB = 8;
  localparam int LO_MSB = 7;
  localparam int LO_LSB = 0;

endpackage

// File: rtl/uart_cmd_rx_timer.sv
// cmd_timeout_timer
// Inter-byte timeout counter for the command-frame receiver.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : count while high; counter is held at 0 while low
//   restart    : restart counting from 0 (a byte was just captured)
//   expire     : high for one cycle while the count sits at TIMEOUT_CLKS-1
//                with no restart in that cycle
module cmd_timeout_timer #(
  parameter int TIMEOUT_CLKS = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] count_q;

  // A restart in the expiry cycle wins, so the byte is taken instead.
  assign expire = enable && !restart && (count_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!enable || restart || expire) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// Assembles three received UART bytes (opcode, data high, data low) into one
// 24-bit command with a sticky ready flag. A partial frame is discarded when
// the gap between its bytes reaches TIMEOUT_CLKS clocks.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_rdy       : byte-ready level from the receiver
//   rx_data      : received byte, valid while rx_rdy=1
//   clr_rx_rdy   : consume strobe back to the receiver (equals rx_rdy)
//   cmd          : last complete frame {opcode, data_hi, data_lo}
//   cmd_rdy      : sticky, cmd holds an unread frame
//   clr_cmd_rdy  : consumer acknowledge, clears cmd_rdy and overrun
//   overrun      : sticky, a frame overwrote cmd while cmd_rdy was set
//   frame_err    : one-cycle pulse after a partial frame timed out
//   busy         : a frame is partially received
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);

  state_t     state_q, state_d;
  logic [7:0] op_q, hi_q;
  logic       capture;
  logic       load_op, load_hi, frame_done;
  logic       timer_expire;
  logic       overrun_set;

  // The receiver holds rx_rdy until cleared, and we always accept at once.
  assign capture    = rx_rdy;
  assign clr_rx_rdy = rx_rdy;
  assign busy       = (state_q != WAIT_OP);

  cmd_timeout_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (busy),
    .restart (capture),
    .expire  (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_OP;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    load_op    = 1'b0;
    load_hi    = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      WAIT_OP: begin
        if (capture) begin
          load_op = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (capture) begin
          load_hi = 1'b1;
          state_d = WAIT_LO;
        end else if (timer_expire) begin
          state_d = WAIT_OP;
        end
      end
      WAIT_LO: begin
        if (capture) begin
          frame_done = 1'b1;
          state_d    = WAIT_OP;
        end else if (timer_expire) begin
          state_d = WAIT_OP;
        end
      end
      default: state_d = WAIT_OP;
    endcase
  end

  // Stale op/hi bytes after a timeout are harmless: they are always
  // rewritten before the next frame can complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      hi_q <= '0;
    end else begin
      if (load_op) op_q <= rx_data;
      if (load_hi) hi_q <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (frame_done) begin
      cmd[OP_MSB:OP_LSB] <= op_q;
      cmd[HI_MSB:HI_LSB] <= hi_q;
      cmd[LO_MSB:LO_LSB] <= rx_data;
    end
  end

  // Completion beats acknowledge so a frame landing with the ack is not lost.
  assign overrun_set = frame_done && cmd_rdy && !clr_cmd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (frame_done)       cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy <= 1'b0;

      if (overrun_set)      overrun <= 1'b1;
      else if (clr_cmd_rdy) overrun <= 1'b0;

      // Expiry only fires with no capture, so the frame is truly abandoned.
      frame_err <= timer_expire;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx with a frame-level reference model.
module tb_uart_cmd_rx;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        overrun;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // Reference model state: bytes of the frame in progress, edge of the last
  // capture, and expected visible outputs.
  logic [7:0]  frame_q[$];
  int          edge_cnt = 0;
  int          last_cap = 0;
  logic [23:0] m_cmd = '0;
  logic        m_cmd_rdy = 1'b0;
  logic        m_overrun = 1'b0;
  logic        m_ferr = 1'b0;

  uart_cmd_rx #(.TIMEOUT_CLKS(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    frame_q.delete();
    m_cmd = '0; m_cmd_rdy = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0;
  endtask

  // Apply the frame rules for one clock edge.
  task automatic model_edge(input logic rdy, input logic [7:0] data, input logic clr);
    logic ferr_next;
    logic done;
    ferr_next = 1'b0;
    done = 1'b0;
    edge_cnt++;
    if (rdy) begin
      frame_q.push_back(data);
      last_cap = edge_cnt;
      if (frame_q.size() == 3) begin
        done = 1'b1;
        if (m_cmd_rdy && !clr) m_overrun = 1'b1;
        else if (clr)          m_overrun = 1'b0;
        m_cmd = {frame_q[0], frame_q[1], frame_q[2]};
        m_cmd_rdy = 1'b1;
        frame_q.delete();
      end
    end else if (frame_q.size() != 0 && edge_cnt - last_cap == T) begin
      frame_q.delete();
      ferr_next = 1'b1;
    end
    if (!done && clr) begin
      m_cmd_rdy = 1'b0;
      m_overrun = 1'b0;
    end
    m_ferr = ferr_next;
  endtask

  // One clock cycle: drive at the falling edge, model the rising edge, then
  // compare every output at the next falling edge.
  task automatic cyc(input logic rdy, input logic [7:0] data, input logic clr);
    rx_rdy = rdy; rx_data = data; clr_cmd_rdy = clr;
    #1;
    checks++;
    if (clr_rx_rdy !== rdy) begin
      failures++;
      $display("FAIL clr_rx_rdy: got %b expected %b", clr_rx_rdy, rdy);
    end
    @(posedge clk);
    model_edge(rdy, data, clr);
    @(negedge clk);
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    checks++;
    if (cmd !== m_cmd || cmd_rdy !== m_cmd_rdy || overrun !== m_overrun ||
        frame_err !== m_ferr || busy !== (frame_q.size() != 0)) begin
      failures++;
      $display("FAIL cycle@%0d: got cmd=%h rdy=%b ovr=%b ferr=%b busy=%b expected cmd=%h rdy=%b ovr=%b ferr=%b busy=%b",
               edge_cnt, cmd, cmd_rdy, overrun, frame_err, busy,
               m_cmd, m_cmd_rdy, m_overrun, m_ferr, frame_q.size() != 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_flags(input string name, input logic [23:0] e_cmd,
                             input logic e_rdy, input logic e_ovr, input logic e_busy);
    checks++;
    if (cmd !== e_cmd || cmd_rdy !== e_rdy || overrun !== e_ovr || busy !== e_busy) begin
      failures++;
      $display("FAIL %s: got cmd=%h rdy=%b ovr=%b busy=%b expected cmd=%h rdy=%b ovr=%b busy=%b",
               name, cmd, cmd_rdy, overrun, busy, e_cmd, e_rdy, e_ovr, e_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (cmd !== 24'h0 || cmd_rdy !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0 ||
        busy !== 1'b0 || clr_rx_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset: got cmd=%h rdy=%b ovr=%b ferr=%b busy=%b clr_rx=%b expected all zero",
               cmd, cmd_rdy, overrun, frame_err, busy, clr_rx_rdy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    cyc(1'b1, 8'hA5, 1'b0); idle(2);
    cyc(1'b1, 8'h12, 1'b0); idle(1);
    cyc(1'b1, 8'h34, 1'b0);
    check_flags("single_frame", 24'hA51234, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h01, 1'b0); cyc(1'b1, 8'h00, 1'b0); cyc(1'b1, 8'h10, 1'b0);
    check_flags("first_frame", 24'h010010, 1'b1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b1, 8'h02, 1'b0); cyc(1'b1, 8'hFF, 1'b0); cyc(1'b1, 8'hEE, 1'b0);
    check_flags("overrun_set", 24'h02FFEE, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check_flags("overrun_clear", 24'h02FFEE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int pulses;
    int pulse_at;
    pulses = 0;
    pulse_at = -1;
    cyc(1'b1, 8'h7E, 1'b0);
    cyc(1'b1, 8'h11, 1'b0);
    for (int k = 1; k <= T + 10; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (frame_err === 1'b1) begin
        pulses++;
        pulse_at = k;
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != T) begin
      failures++;
      $display("FAIL timeout_pulse: got %0d pulses, last after %0d cycles; expected 1 after %0d",
               pulses, pulse_at, T);
    end
    check_flags("timeout_keeps_cmd", 24'h02FFEE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0); cyc(1'b1, 8'h00, 1'b0); cyc(1'b1, 8'h05, 1'b0);
    check_flags("after_timeout", 24'hC30005, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_clr_coincide();
    cyc(1'b1, 8'h5A, 1'b0); cyc(1'b1, 8'h6B, 1'b0); cyc(1'b1, 8'h7C, 1'b1);
    check_flags("clr_coincide", 24'h5A6B7C, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_capture_at_expiry();
    int errs;
    errs = 0;
    cyc(1'b1, 8'h99, 1'b0);
    for (int k = 1; k < T; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (frame_err === 1'b1) errs++;
    end
    cyc(1'b1, 8'h88, 1'b0);
    if (frame_err === 1'b1) errs++;
    for (int k = 1; k < T; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (frame_err === 1'b1) errs++;
    end
    cyc(1'b1, 8'h77, 1'b0);
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL capture_at_expiry: got %0d frame_err pulses expected 0", errs);
    end
    check_flags("expiry_frame", 24'h998877, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    cyc(1'b1, 8'hDE, 1'b0); cyc(1'b1, 8'hAD, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cmd_rdy !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0 ||
        cmd !== 24'h0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b rdy=%b ovr=%b ferr=%b cmd=%h expected all zero",
               busy, cmd_rdy, overrun, frame_err, cmd);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h10, 1'b0); cyc(1'b1, 8'h20, 1'b0); cyc(1'b1, 8'h30, 1'b0);
    check_flags("after_reset", 24'h102030, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int gap;
      gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(T - 2, T + 3))
                                         : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++)
        cyc(1'b0, 8'h00, ($urandom_range(0, 7) == 0));
      cyc(1'b1, 8'($urandom), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_overrun();
    test_timeout();
    test_clr_coincide();
    test_capture_at_expiry();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Command-frame controller that sits directly behind the byte-level UART receiver. It consumes received bytes through the receiver's ready/clear handshake and assembles three-byte frames: opcode, then data high byte, then data low byte. Each complete frame is presented to the command decoder as one 24-bit command with a sticky ready flag. An inter-byte timeout discards partial frames so the link resynchronises after a dropped byte.

## Interface
Parameters:
- TIMEOUT_CLKS, default 100_000: clocks allowed between bytes of one frame before the partial frame is discarded; must be ≥ 2. Counter width is $clog2(TIMEOUT_CLKS).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- rx_rdy  in  1  byte-ready level from the receiver; stays high until cleared.
- rx_data  in  8  received byte; valid while rx_rdy=1.
- clr_rx_rdy  out  1  consume strobe to the receiver; combinational, equals rx_rdy.
- cmd  out  24  last complete frame: {opcode[23:16], data_hi[15:8], data_lo[7:0]}.
- cmd_rdy  out  1  sticky; a complete frame is held in cmd.
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy and overrun.
- overrun  out  1  sticky; a new frame overwrote cmd while cmd_rdy=1.
- frame_err  out  1  one-cycle pulse; partial frame discarded on timeout.
- busy  out  1  high when state ≠ WAIT_OP.

## Operation
- States: WAIT_OP, WAIT_HI, WAIT_LO. Reset state is WAIT_OP.
- A byte is captured on any clock edge where rx_rdy=1. clr_rx_rdy is high in that same cycle. The receiver drops rx_rdy on that edge, so each byte is captured exactly once.
- WAIT_OP: on capture, op_reg ← rx_data; go to WAIT_HI.
- WAIT_HI: on capture, hi_reg ← rx_data; go to WAIT_LO.
- WAIT_LO: on capture, cmd ← {op_reg, hi_reg, rx_data}; cmd_rdy ← 1; go to WAIT_OP.
- cmd_rdy:
  - set by frame completion;
  - otherwise cleared by clr_cmd_rdy;
  - set wins when both occur in the same cycle.
- overrun:
  - set when a frame completes while cmd_rdy=1 and clr_cmd_rdy=0; cmd is overwritten with the new frame;
  - cleared by clr_cmd_rdy only when no overrun is being set in that cycle.
- Timeout counter:
  - held at 0 in WAIT_OP;
  - reset to 0 on every capture;
  - otherwise increments each cycle in WAIT_HI/WAIT_LO.
- When the counter reaches TIMEOUT_CLKS-1 with no capture in that cycle: next state is WAIT_OP, frame_err pulses on the following cycle, op_reg/hi_reg contents are ignored, and cmd/cmd_rdy are unchanged.
- If a capture and expiry coincide, the capture wins: the byte is taken, the counter resets and no frame_err is raised.
- cmd changes only on frame completion. The consumer reads cmd any time cmd_rdy=1.

## Timing
- Reset values: cmd=0, cmd_rdy=0, overrun=0, frame_err=0, busy=0, counter=0, op_reg=hi_reg=0.
- clr_rx_rdy is 0 during reset because the receiver's rdy resets low.
- Latency: third byte's rx_rdy high in cycle N → cmd valid and cmd_rdy=1 in cycle N+1.
- Back-to-back bytes (rx_rdy high again in cycle N+1) are accepted with no bubble.
- Expiry: if the last capture was at edge E, a missing byte is declared at the edge E+TIMEOUT_CLKS, and frame_err is high for the cycle after that edge.
- Reset asserted mid-frame: returns to WAIT_OP immediately (asynchronous), discards the partial frame, and clears all flags.

## Structure
- Package uart_cmd_pkg holds:
  - the state enum state_t {WAIT_OP, WAIT_HI, WAIT_LO};
  - localparams FRAME_BYTES=3 and the OP_MSB/OP_LSB, HI_MSB/HI_LSB, LO_MSB/LO_LSB field positions.
- One sub-module, cmd_timeout_timer (parameter TIMEOUT_CLKS):
  - inputs clk, rst_n, enable, restart;
  - output expire, high for one cycle at the count of TIMEOUT_CLKS-1.
- The FSM, byte registers and flag logic stay in uart_cmd_rx.

## Test plan
- Bytes 0xA5, 0x12, 0x34 each held by a receiver model → cmd=0xA51234 and cmd_rdy=1 one cycle after the third capture; busy=0; overrun=0.
- Two frames, 0x01 0x00 0x10 then 0x02 0xFF 0xEE, with no clr_cmd_rdy → cmd=0x02FFEE, overrun=1; one-cycle clr_cmd_rdy → cmd_rdy=0, overrun=0.
- TIMEOUT_CLKS=50; send 0x7E, 0x11, then silence → frame_err pulses exactly once, 50 cycles after the 0x11 capture; then 0xC3, 0x00, 0x05 → cmd=0xC30005.
- clr_cmd_rdy asserted in the same cycle a frame completes → cmd_rdy=1 afterwards and overrun=0.
- Byte arrives in the cycle the counter hits TIMEOUT_CLKS-1 → no frame_err; the frame completes normally with the next byte.
- rst_n pulsed low after the second byte → busy=0 and all flags are 0; the following three bytes 0x10 0x20 0x30 give cmd=0x102030.
